mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multi-cycle MIPS control sequencer. It replaces the single-cycle decoder when the datapath shares one memory and one ALU across cycles.
- Drives PC, IR, register-file, ALU and memory-port controls state by state from the IR opcode/funct fields.
- Waits on a memory ready handshake.
- Supports R-type (add/and/or/slt/sll), jr, addi, ori, lw, sw, beq, j, jal. Reports illegal opcodes.

Parameters:
TRAP_ILLEGAL, 1, 1: unknown opcode -> HALT; 0: unknown opcode retires as NOP (-> FETCH)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  6  IR[31:26], stable from DECODE until return to FETCH
func  in  6  IR[5:0]
mem_ready  in  1  memory access complete this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (beq)
iord  out  1  memory address mux: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
reg_dst  out  1  write register: 0=rt, 1=rd
mem_to_reg  out  1  write data: 0=ALUOut, 1=MDR
reg_write  out  1  register file write enable
jal  out  1  force write address $31, write data = PC
alu_src_a  out  1  0=PC, 1=reg A
alu_src_b  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  out  2  00=add, 01=sub, 10=funct, 11=or
zero_ext  out  1  immediate zero-extended (ori)
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=reg A (jr)
instr_done  out  1  one-cycle pulse when an instruction retires
illegal  out  1  sticky flag; cleared only by reset
state  out  4  current state (debug)

Behaviour:
- Reset: on a clk edge with reset=1, state<=IDLE (0) and illegal<=0. In IDLE every control output is 0. IDLE->FETCH unconditionally on the next cycle.
- Outputs are Moore decodes of state. Exceptions: pc_write/ir_write in FETCH and state advance in memory states, which are gated by mem_ready in the same cycle.
- Any output not listed for a state is 0.
- States (4-bit encoding):
  - FETCH(1): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. If mem_ready: ir_write=1, pc_write=1, next=DECODE; else stay.
  - DECODE(2): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
    - 000000 & func=001000 -> JR; 000000 otherwise -> R_EXEC
    - 100011/101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 000011 -> JAL
    - 001000/001101 -> I_EXEC
    - else illegal<=1 and -> HALT (TRAP_ILLEGAL=1) or FETCH with instr_done=1 (TRAP_ILLEGAL=0).
  - MEM_ADDR(3): alu_src_a=1, alu_src_b=10, alu_op=00. Next: lw->MEM_RD, sw->MEM_WR.
  - MEM_RD(4): mem_read=1, iord=1. Stay until mem_ready, then MEM_WB.
  - MEM_WB(5): reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1 -> FETCH.
  - MEM_WR(6): mem_write=1, iord=1. Stay until mem_ready, then instr_done=1 -> FETCH.
  - R_EXEC(7): alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
  - R_WB(8): reg_dst=1, reg_write=1, instr_done=1 -> FETCH.
  - BRANCH(9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1 -> FETCH.
  - JUMP(10): pc_write=1, pc_source=10, instr_done=1 -> FETCH.
  - I_EXEC(11): alu_src_a=1, alu_src_b=10. addi: alu_op=00, zero_ext=0. ori: alu_op=11, zero_ext=1. -> I_WB.
  - I_WB(12): reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1 -> FETCH. zero_ext holds ori value.
  - JR(13): pc_write=1, pc_source=11, instr_done=1 -> FETCH.
  - JAL(14): jal=1, reg_write=1, pc_write=1, pc_source=10, instr_done=1 -> FETCH. The PC already holds PC+4, so $31 gets the return address in the same cycle as the PC update.
  - HALT(15): all controls 0; exits only by reset.
  - Encodings 0 and 1..15 as listed; undefined values are unreachable. Any other value -> IDLE.
- mem_read/mem_write are held high, with iord stable, for every cycle until mem_ready; no retraction.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- reset has priority over every transition, including mid-wait in a memory state. The request drops in the cycle after the reset edge.
- Latency with zero-wait memory: lw 5 cycles; sw, R-type, addi, ori 4; beq, j, jr, jal 3.

Test Plan:
- Reset held 2 cycles, then released -> state IDLE (outputs all 0) for 1 cycle, then FETCH with mem_read=1, alu_src_b=01.
- lw (opcode 100011), mem_ready=1 always -> states 1,2,3,4,5; reg_write=1 with mem_to_reg=1 only in MEM_WB; instr_done pulses on cycle 5.
- sw (101011), mem_ready low 3 cycles in MEM_WR -> mem_write and iord=1 held 4 cycles; single instr_done on the ready cycle; reg_write never 1.
- FETCH with mem_ready=0 for 2 cycles -> ir_write/pc_write 0 for those cycles and 1 only in the ready cycle.
- jal (000011) then jr (000000/001000) -> JAL: jal=1, reg_write=1, pc_source=10. JR: pc_source=11, reg_write=0. Each takes 3 cycles.
- Opcode 111111: with TRAP_ILLEGAL=1 -> illegal=1, state 15 held until reset. With TRAP_ILLEGAL=0 -> illegal=1, instr_done pulse, back to FETCH. Reset asserted in MEM_RD -> IDLE next cycle, illegal cleared.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer: steps PC/IR/regfile/ALU/memory controls
// state by state from the IR opcode/funct fields, waiting on mem_ready.
module mc_control_fsm #(
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       jal,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       zero_ext,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  // state    | meaning
  // IDLE     | post-reset, all controls low
  // FETCH    | read instruction at PC, PC <= PC+4 on ready
  // DECODE   | branch target into ALUOut, dispatch on opcode
  // MEM_ADDR | effective address for lw/sw
  // MEM_RD   | data read, wait for ready
  // MEM_WB   | MDR -> rt
  // MEM_WR   | data write, wait for ready
  // R_EXEC   | ALU op from funct
  // R_WB     | ALUOut -> rd
  // BRANCH   | beq compare and conditional PC load
  // JUMP     | PC <= jump target
  // I_EXEC   | addi/ori ALU op
  // I_WB     | ALUOut -> rt
  // JR       | PC <= reg A
  // JAL      | $31 <= PC, PC <= jump target
  // HALT     | trapped on illegal opcode, exits only by reset
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12,
    S_JR       = 4'd13,
    S_JAL      = 4'd14,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    jal           = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    zero_ext      = 1'b0;
    pc_source     = 2'b00;
    instr_done    = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:     state_d = (func == FN_JR) ? S_JR : S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          OP_ADDI,
          OP_ORI:       state_d = S_I_EXEC;
          default: begin
            illegal_d = 1'b1;
            if (TRAP_ILLEGAL) begin
              state_d = S_HALT;
            end else begin
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
          end
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end

      S_R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end

      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == OP_ORI) ? 2'b11 : 2'b00;
        zero_ext  = (opcode == OP_ORI);
        state_d   = S_I_WB;
      end

      // zero_ext stays valid through writeback so the immediate path is stable
      S_I_WB: begin
        reg_write  = 1'b1;
        zero_ext   = (opcode == OP_ORI);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JR: begin
        pc_write   = 1'b1;
        pc_source  = 2'b11;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JAL: begin
        jal        = 1'b1;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IDLE;
    endcase
  end

  assign state   = state_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: two instances (trap / no-trap) checked cycle by
// cycle against per-instruction control sequences with random memory waits.
module tb_mc_control_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_r [2];
  logic [5:0]  opc_r   [2];
  logic [5:0]  fn_r    [2];
  logic        mr_r    [2];
  logic [19:0] obs     [2];
  logic [3:0]  st_o    [2];
  logic        ill_o   [2];

  localparam int PCW = 19, PCWC = 18, IORD = 17, MRD = 16, MWR = 15, IRW = 14;
  localparam int RDST = 13, M2R = 12, RW = 11, JAL = 10, ASA = 9, ASB = 7;
  localparam int AOP = 5, ZX = 4, PCS = 2, DONE = 1;

  for (genvar g = 0; g < 2; g++) begin : gd
    logic pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, jl, asa, zx, done;
    logic [1:0] asb, aop, pcs;
    mc_control_fsm #(.TRAP_ILLEGAL(g == 0)) u_dut (
      .clk(clk), .reset(reset_r[g]), .opcode(opc_r[g]), .func(fn_r[g]),
      .mem_ready(mr_r[g]), .pc_write(pcw), .pc_write_cond(pcwc), .iord(iord),
      .mem_read(mrd), .mem_write(mwr), .ir_write(irw), .reg_dst(rdst),
      .mem_to_reg(m2r), .reg_write(rw), .jal(jl), .alu_src_a(asa),
      .alu_src_b(asb), .alu_op(aop), .zero_ext(zx), .pc_source(pcs),
      .instr_done(done), .illegal(ill_o[g]), .state(st_o[g])
    );
    assign obs[g] = {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, jl, asa,
                     asb, aop, zx, pcs, done, 1'b0};
  end

  typedef struct packed {
    logic [3:0]  st;
    logic [19:0] ctl;
    logic [19:0] rctl;
    logic        w;
    logic        seti;
  } rec_t;

  rec_t       q[$];
  int         n_chk = 0, n_err = 0;
  bit         ill_exp [2];
  logic [5:0] pend_opc [2];
  logic [5:0] pend_fn  [2];
  int         mode = 1, fixed_wait = 0;
  int         done_seen, rw_seen, irw_seen;
  int         st_cnt [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] b(input int p);
    return 20'(1) << p;
  endfunction

  function automatic logic [19:0] f(input int lsb, input int v);
    return 20'(v) << lsb;
  endfunction

  function automatic rec_t R(input int st, input logic [19:0] ctl,
                             input logic [19:0] rctl, input bit w, input bit seti);
    rec_t r;
    r.st = 4'(st); r.ctl = ctl; r.rctl = rctl; r.w = w; r.seti = seti;
    return r;
  endfunction

  function automatic bit is_legal(input logic [5:0] opc);
    return opc inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h0d, 6'h23, 6'h2b};
  endfunction

  function automatic int lat(input logic [5:0] opc, input logic [5:0] fn);
    case (opc)
      6'h23:               return 5;
      6'h2b, 6'h08, 6'h0d: return 4;
      6'h00:               return (fn == 6'h08) ? 3 : 4;
      default:             return 3;
    endcase
  endfunction

  // Expected per-cycle control sequence of one instruction
  task automatic build(input logic [5:0] opc, input logic [5:0] fn, input bit trap);
    bit ill;
    logic [19:0] dc;
    ill = !is_legal(opc);
    q.delete();
    q.push_back(R(1, b(MRD) | f(ASB, 1), b(PCW) | b(IRW), 1'b1, 1'b0));
    dc = f(ASB, 3);
    if (ill && !trap) dc |= b(DONE);
    q.push_back(R(2, dc, 20'h0, 1'b0, ill));
    if (ill) begin
      if (trap) for (int i = 0; i < 4; i++) q.push_back(R(15, 20'h0, 20'h0, 1'b0, 1'b0));
    end else begin
      case (opc)
        6'h23: begin
          q.push_back(R(3, b(ASA) | f(ASB, 2), 20'h0, 1'b0, 1'b0));
          q.push_back(R(4, b(MRD) | b(IORD), 20'h0, 1'b1, 1'b0));
          q.push_back(R(5, b(M2R) | b(RW) | b(DONE), 20'h0, 1'b0, 1'b0));
        end
        6'h2b: begin
          q.push_back(R(3, b(ASA) | f(ASB, 2), 20'h0, 1'b0, 1'b0));
          q.push_back(R(6, b(MWR) | b(IORD), b(DONE), 1'b1, 1'b0));
        end
        6'h00: begin
          if (fn == 6'h08) q.push_back(R(13, b(PCW) | f(PCS, 3) | b(DONE), 20'h0, 1'b0, 1'b0));
          else begin
            q.push_back(R(7, b(ASA) | f(AOP, 2), 20'h0, 1'b0, 1'b0));
            q.push_back(R(8, b(RDST) | b(RW) | b(DONE), 20'h0, 1'b0, 1'b0));
          end
        end
        6'h04: q.push_back(R(9, b(ASA) | f(AOP, 1) | b(PCWC) | f(PCS, 1) | b(DONE), 20'h0, 1'b0, 1'b0));
        6'h02: q.push_back(R(10, b(PCW) | f(PCS, 2) | b(DONE), 20'h0, 1'b0, 1'b0));
        6'h03: q.push_back(R(14, b(JAL) | b(RW) | b(PCW) | f(PCS, 2) | b(DONE), 20'h0, 1'b0, 1'b0));
        6'h08: begin
          q.push_back(R(11, b(ASA) | f(ASB, 2), 20'h0, 1'b0, 1'b0));
          q.push_back(R(12, b(RW) | b(DONE), 20'h0, 1'b0, 1'b0));
        end
        default: begin
          q.push_back(R(11, b(ASA) | f(ASB, 2) | f(AOP, 3) | b(ZX), 20'h0, 1'b0, 1'b0));
          q.push_back(R(12, b(RW) | b(DONE) | b(ZX), 20'h0, 1'b0, 1'b0));
        end
      endcase
    end
  endtask

  task automatic step(input int d, input rec_t r, input int wcnt, output bit adv);
    logic [19:0] e;
    bit m;
    @(posedge clk);
    #1;
    if (r.st == 4'd1) begin
      opc_r[d] = pend_opc[d];
      fn_r[d]  = pend_fn[d];
    end
    if (r.w) begin
      case (mode)
        1:       m = 1'b1;
        2:       m = (wcnt >= fixed_wait);
        default: m = (wcnt >= 6) || ($urandom_range(0, 2) == 0);
      endcase
    end else begin
      m = 1'($urandom_range(0, 1));
    end
    mr_r[d] = m;
    #1;
    e = r.ctl | (m ? r.rctl : 20'h0);
    chk($sformatf("d%0d_state", d), 32'(st_o[d]), 32'(r.st));
    chk($sformatf("d%0d_ctl_s%0d", d, r.st), 32'(obs[d]), 32'(e));
    chk($sformatf("d%0d_illegal", d), 32'(ill_o[d]), 32'(ill_exp[d]));
    if (obs[d][DONE]) done_seen++;
    if (obs[d][RW])   rw_seen++;
    if (obs[d][IRW])  irw_seen++;
    st_cnt[r.st]++;
    adv = !r.w || m;
    if (adv && r.seti) ill_exp[d] = 1'b1;
  endtask

  task automatic run_instr(input int d, input logic [5:0] opc, input logic [5:0] fn,
                           output int cyc);
    bit trap;
    trap = (d == 0);
    build(opc, fn, trap);
    pend_opc[d] = opc;
    pend_fn[d]  = fn;
    cyc = 0; done_seen = 0; rw_seen = 0; irw_seen = 0;
    for (int s = 0; s < 16; s++) st_cnt[s] = 0;
    foreach (q[i]) begin
      int  w;
      bit  adv;
      w = 0; adv = 1'b0;
      while (!adv) begin
        step(d, q[i], w, adv);
        cyc++; w++;
        if (w > 30) begin
          chk("wait_timeout", 32'(w), 32'd30);
          adv = 1'b1;
        end
      end
    end
    chk($sformatf("d%0d_done_cnt_op%0h", d, opc), 32'(done_seen),
        (!is_legal(opc) && trap) ? 32'd0 : 32'd1);
  endtask

  task automatic do_reset(input int d);
    @(posedge clk);
    #1;
    reset_r[d] = 1'b1;
    mr_r[d]    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_r[d] = 1'b0;
    ill_exp[d] = 1'b0;
    #1;
    chk($sformatf("d%0d_rst_state", d), 32'(st_o[d]), 32'd0);
    chk($sformatf("d%0d_rst_ctl", d), 32'(obs[d]), 32'd0);
    chk($sformatf("d%0d_rst_illegal", d), 32'(ill_o[d]), 32'd0);
  endtask

  function automatic logic [5:0] rand_legal(output logic [5:0] fn);
    logic [5:0] ops [9];
    logic [5:0] fns [6];
    int k;
    ops = '{6'h23, 6'h2b, 6'h00, 6'h00, 6'h04, 6'h02, 6'h03, 6'h08, 6'h0d};
    fns = '{6'h20, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h08};
    k = $urandom_range(0, 8);
    fn = fns[$urandom_range(0, 5)];
    return ops[k];
  endfunction

  initial begin
    int cyc;
    bit adv;
    logic [5:0] op, fn;
    logic [5:0] dir_op [9];
    logic [5:0] dir_fn [9];
    dir_op = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h02, 6'h03, 6'h00, 6'h08, 6'h0d};
    dir_fn = '{6'h00, 6'h00, 6'h20, 6'h00, 6'h00, 6'h00, 6'h08, 6'h00, 6'h00};
    for (int i = 0; i < 2; i++) begin
      reset_r[i] = 1'b1; opc_r[i] = 6'h0; fn_r[i] = 6'h0; mr_r[i] = 1'b0;
      ill_exp[i] = 1'b0; pend_opc[i] = 6'h0; pend_fn[i] = 6'h0;
    end

    // trapping instance: zero-wait latency of every instruction class
    do_reset(0);
    mode = 1;
    for (int i = 0; i < 9; i++) begin
      run_instr(0, dir_op[i], dir_fn[i], cyc);
      chk($sformatf("lat_op%0h_fn%0h", dir_op[i], dir_fn[i]), 32'(cyc),
          32'(lat(dir_op[i], dir_fn[i])));
    end

    mode = 2; fixed_wait = 3;
    run_instr(0, 6'h2b, 6'h00, cyc);
    chk("sw_memwr_cycles", 32'(st_cnt[6]), 32'd4);
    chk("sw_no_regwrite", 32'(rw_seen), 32'd0);

    fixed_wait = 2;
    run_instr(0, 6'h00, 6'h25, cyc);
    chk("fetch_wait_cycles", 32'(st_cnt[1]), 32'd3);
    chk("fetch_irwrite_cnt", 32'(irw_seen), 32'd1);

    mode = 0;
    for (int n = 0; n < 60; n++) begin
      op = rand_legal(fn);
      run_instr(0, op, fn, cyc);
    end

    mode = 1;
    run_instr(0, 6'h3f, 6'h00, cyc);
    do_reset(0);
    run_instr(0, 6'h0d, 6'h00, cyc);

    // non-trapping instance: illegal opcodes retire as NOPs
    do_reset(1);
    mode = 0;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 6'(($urandom_range(0, 1) == 0) ? 6'h3f : 6'h11);
        fn = 6'h00;
      end else begin
        op = rand_legal(fn);
      end
      run_instr(1, op, fn, cyc);
    end
    mode = 1;
    run_instr(1, 6'h3f, 6'h00, cyc);
    chk("nop_illegal_lat", 32'(cyc), 32'd2);

    // reset while waiting in MEM_RD
    build(6'h23, 6'h00, 1'b0);
    pend_opc[1] = 6'h23; pend_fn[1] = 6'h00;
    for (int i = 0; i < 3; i++) step(1, q[i], 0, adv);
    @(posedge clk);
    #1;
    mr_r[1]    = 1'b0;
    reset_r[1] = 1'b1;
    #1;
    chk("memrd_state", 32'(st_o[1]), 32'd4);
    chk("memrd_ctl", 32'(obs[1]), 32'(b(MRD) | b(IORD)));
    chk("memrd_illegal", 32'(ill_o[1]), 32'd1);
    @(posedge clk);
    #1;
    reset_r[1] = 1'b0;
    #1;
    chk("memrd_rst_state", 32'(st_o[1]), 32'd0);
    chk("memrd_rst_ctl", 32'(obs[1]), 32'd0);
    chk("memrd_rst_illegal", 32'(ill_o[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
